// File: rtl/flit_queue.sv
//==============================================================================
// Module   : flit_queue (with package types)
// Brief    : First-word fall-through flit FIFO with valid/ready handshakes on
//            both sides and occupancy-based flow control.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package types;
  typedef struct packed {
    logic [7:0]  src_id;
    logic [7:0]  dst_id;
    logic [15:0] payload;
  } flit_t;
endpackage

module flit_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  types::flit_t pushed_flit,
  input  logic         pushed_flit_valid,
  output logic         pushed_flit_ready,
  input  logic         poped_flit_ready,
  output logic         poped_flit_valid,
  output types::flit_t poped_flit
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_empty = '0;

  types::flit_t         r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic w_push;
  logic w_pop;

  // Flow control looks only at registered occupancy, so no ready/valid loop
  // can form between producer and consumer.
  assign pushed_flit_ready = (r_count != c_full);
  assign poped_flit_valid  = (r_count != c_empty);
  assign poped_flit        = poped_flit_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = pushed_flit_valid && pushed_flit_ready;
  assign w_pop  = poped_flit_ready  && poped_flit_valid;

  // Storage is deliberately left unreset; the count masks stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pushed_flit;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flit_queue.sv
//==============================================================================
// Module   : tb_flit_queue
// Brief    : Directed scoreboard bench for flit_queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_flit_queue;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  types::flit_t pushed_flit;
  logic         pushed_flit_valid;
  logic         pushed_flit_ready;
  logic         poped_flit_ready;
  logic         poped_flit_valid;
  types::flit_t poped_flit;

  int n_checks;
  int n_errors;
  types::flit_t sb [$];

  flit_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pushed_flit       (pushed_flit),
    .pushed_flit_valid (pushed_flit_valid),
    .pushed_flit_ready (pushed_flit_ready),
    .poped_flit_ready  (poped_flit_ready),
    .poped_flit_valid  (poped_flit_valid),
    .poped_flit        (poped_flit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic types::flit_t mk(input logic [7:0] src);
    types::flit_t f;
    f.src_id  = src;
    f.dst_id  = ~src;
    f.payload = {src ^ 8'h5A, src + 8'h33};
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare DUT state against the scoreboard before
  // the edge, then advance the model with the handshakes that will occur.
  task automatic cycle(input bit push, input logic [7:0] src, input bit pop);
    bit do_push;
    bit do_pop;
    types::flit_t exp_head;
    pushed_flit_valid = push;
    pushed_flit       = mk(src);
    poped_flit_ready  = pop;
    exp_head = (sb.size() != 0) ? sb[0] : '0;
    chk("valid", 32'(poped_flit_valid), 32'(sb.size() != 0));
    chk("ready", 32'(pushed_flit_ready), 32'(sb.size() < DEPTH));
    chk("head",  poped_flit, exp_head);
    do_push = push && (sb.size() < DEPTH);
    do_pop  = pop  && (sb.size() != 0);
    @(posedge clk);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back(mk(src));
    #1;
    pushed_flit_valid = 1'b0;
    poped_flit_ready  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    pushed_flit = '0;
    pushed_flit_valid = 1'b0;
    poped_flit_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(poped_flit_valid), 32'd0);
    chk("rst_ready", 32'(pushed_flit_ready), 32'd1);
    chk("rst_flit",  poped_flit, 32'd0);
    rst_n = 1'b1;

    // Single flit, zero-latency fall-through, then drain
    cycle(1, 8'h01, 0);
    chk("lat_src", 32'(poped_flit.src_id), 32'h01);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Head holds while pushing, then pops in order
    cycle(1, 8'h02, 0);
    cycle(1, 8'h03, 0);
    cycle(1, 8'h04, 0);
    chk("hold_src", 32'(poped_flit.src_id), 32'h02);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    chk("only_04", 32'(poped_flit.src_id), 32'h04);

    // Simultaneous push and pop with single entry
    cycle(1, 8'h05, 1);
    chk("simul_src", 32'(poped_flit.src_id), 32'h05);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'h10 + 8'(i), 0);
    cycle(1, 8'hEE, 0);
    chk("full_ready", 32'(pushed_flit_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1);
    cycle(1, 8'h00, 1);
    cycle(0, 8'h00, 1);

    // Wrap-around: 3*DEPTH interleaved pushes with mixed pop patterns
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle(1, 8'h40 + 8'(i), (i % 3) != 0);
    end
    while (sb.size() != 0) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Asynchronous reset mid-operation
    cycle(1, 8'h61, 0);
    cycle(1, 8'h62, 0);
    cycle(0, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(poped_flit_valid), 32'd0);
    chk("arst_ready", 32'(pushed_flit_ready), 32'd1);
    chk("arst_flit",  poped_flit, 32'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    cycle(0, 8'h00, 0);
    cycle(1, 8'h70, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
